// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding and default SRAM geometry for the burst master.
package sram_pkg;
  localparam int SRAM_DATA_LEN = 32;
  localparam int SRAM_N_ENTRIES = 1024;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry FIFO; head is visible combinationally on data_o.
module skid_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic rp_q, rp_d, wp_q, wp_d;
  logic [1:0] cnt_q, cnt_d;
  assign data_o = mem_q[rp_q];
  assign full_o = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wp_q] = data_i;
    wp_d = push_i ? ~wp_q : wp_q;
    rp_d = pop_i ? ~rp_q : rp_q;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sram_burst_master.sv
// sram_burst_master: moves bursts between valid/ready streams and a single-port SRAM
// with a one-cycle registered read.
module sram_burst_master
  import sram_pkg::*;
#(
  parameter int DATA_LEN = SRAM_DATA_LEN,
  parameter int N_ENTRIES = SRAM_N_ENTRIES,
  parameter int AW = $clog2(N_ENTRIES),
  parameter int LW = AW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [AW-1:0]       cmd_addr_i,
  input  logic [LW-1:0]       cmd_len_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [DATA_LEN-1:0] wr_data_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [DATA_LEN-1:0] rd_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                sram_en_o,
  output logic                sram_we_o,
  output logic [AW-1:0]       sram_addr_o,
  output logic [DATA_LEN-1:0] sram_data_o,
  input  logic [DATA_LEN-1:0] sram_data_i
);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc;
  logic [LW-1:0] rem_q, rem_d, iss_q, iss_d;
  logic inflight_q, inflight_d;
  logic wr_hs, issue, pop, fifo_full, fifo_empty;
  logic [2:0] occ;
  assign addr_inc = (addr_q == AW'(N_ENTRIES - 1)) ? '0 : addr_q + AW'(1);
  assign occ = (fifo_full ? 3'd2 : {2'b0, !fifo_empty}) + {2'b0, inflight_q};
  assign wr_ready_o = (state_q == WRITE) && (rem_q != '0);
  assign wr_hs = wr_ready_o && wr_valid_i;
  assign rd_valid_o = (state_q == READ) && !fifo_empty;
  assign pop = rd_valid_o && rd_ready_i;
  // the word still in the SRAM pipeline already owns a FIFO slot
  assign issue = (state_q == READ) && (iss_q != '0) && (occ < 3'd2 + {2'b0, pop});
  assign inflight_d = issue;
  assign cmd_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign sram_en_o = wr_hs || issue;
  assign sram_we_o = wr_hs;
  assign sram_addr_o = addr_q;
  assign sram_data_o = wr_data_i;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    iss_d = iss_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        addr_d = cmd_addr_i;
        rem_d = cmd_len_i;
        iss_d = cmd_len_i;
        state_d = (cmd_len_i == '0) ? DONE : cmd_write_i ? WRITE : READ;
      end
      WRITE: if (wr_hs) begin
        addr_d = addr_inc;
        rem_d = rem_q - LW'(1);
        state_d = (rem_q == LW'(1)) ? DONE : WRITE;
      end
      READ: begin
        addr_d = issue ? addr_inc : addr_q;
        iss_d = issue ? iss_q - LW'(1) : iss_q;
        rem_d = pop ? rem_q - LW'(1) : rem_q;
        state_d = (pop && rem_q == LW'(1)) ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      iss_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      iss_q <= iss_d;
      inflight_q <= inflight_d;
    end
  end
  skid_fifo2 #(.W(DATA_LEN)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(inflight_q),
    .pop_i(pop),
    .data_i(sram_data_i),
    .data_o(rd_data_o),
    .full_o(fifo_full),
    .empty_o(fifo_empty)
  );
endmodule
